dram_port_arbiter: RTL and testbench



---
 rtl/dram_pkg.sv | 44 ++++
 rtl/rr_arb2.sv | 78 +++++++
 rtl/dram_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_dram_port_arbiter.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// -----------------------------------------------------------------------------
// dram_pkg
// Shared types and constants for the DRAM port: field widths, the request and
// response bundles, the arbiter state encoding and the round-robin tie-break.
// No ports (package).
// -----------------------------------------------------------------------------
package dram_pkg;

    localparam int DRAM_ID_W   = 4;
    localparam int DRAM_ADDR_W = 32;
    localparam int DRAM_DATA_W = 128;
    localparam int DRAM_MASK_W = 16;

    typedef struct packed {
        logic [DRAM_ID_W-1:0]   id;
        logic [DRAM_ADDR_W-1:0] addr;
        logic [DRAM_DATA_W-1:0] data;
        logic                   isWr;
        logic [DRAM_MASK_W-1:0] mask;
    } dram_req_t;

    typedef struct packed {
        logic [DRAM_ID_W-1:0]   id;
        logic [DRAM_DATA_W-1:0] data;
    } dram_resp_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Two-way pick: a lone eligible client wins outright, a tie goes to ptr.
    function automatic logic rr_pick(input logic [1:0] elig, input logic ptr);
        logic pick;
        case (elig)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = ptr;
            default: pick = 1'b0;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter with grant lock. In IDLE the grant is chosen
// combinationally among eligible requesters; if the downstream does not accept
// in that cycle the grant is locked onto that requester until it fires.
// Ports:
//   clock, reset     system clock, synchronous active-high reset
//   req_valid_i[1:0] raw request valids (used while locked)
//   req_elig_i[1:0]  valid and below the outstanding cap (used while idle)
//   ready_i          downstream request ready
//   gnt_idx_o        granted client index
//   gnt_valid_o      a grant is presented downstream (0 during reset)
//   locked_o         grant lock currently held
// -----------------------------------------------------------------------------
module rr_arb2
    import dram_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req_valid_i,
    input  logic [1:0] req_elig_i,
    input  logic       ready_i,
    output logic       gnt_idx_o,
    output logic       gnt_valid_o,
    output logic       locked_o
);

    arb_state_e state_q;
    logic       owner_q;
    logic       rr_ptr_q;

    always_comb begin
        gnt_idx_o   = 1'b0;
        gnt_valid_o = 1'b0;
        if (state_q == ARB_LOCKED) begin
            // The owner keeps the port whatever the other client does.
            gnt_idx_o   = owner_q;
            gnt_valid_o = req_valid_i[owner_q];
        end else begin
            gnt_idx_o   = rr_pick(req_elig_i, rr_ptr_q);
            gnt_valid_o = |req_elig_i;
        end
        if (reset) begin
            gnt_valid_o = 1'b0;
        end
    end

    assign locked_o = (state_q == ARB_LOCKED);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            owner_q  <= 1'b0;
            rr_ptr_q <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (gnt_valid_o) begin
                        if (ready_i) begin
                            rr_ptr_q <= ~gnt_idx_o;
                        end else begin
                            state_q <= ARB_LOCKED;
                            owner_q <= gnt_idx_o;
                        end
                    end
                end
                ARB_LOCKED: begin
                    if (gnt_valid_o && ready_i) begin
                        state_q  <= ARB_IDLE;
                        rr_ptr_q <= ~owner_q;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// -----------------------------------------------------------------------------
// dram_port_arbiter
// Shares one DRAM request/response port between client 0 (instruction fetch)
// and client 1 (data cache). Requests are round-robin arbitrated with a grant
// lock, tagged with the client index in id[3]; responses are routed back by
// that tag. Per-client outstanding counters cap in-flight requests, and a
// response arriving for a client with nothing outstanding raises sticky err.
// Ports:
//   clock, reset                     clock, synchronous active-high reset
//   cN_req_valid/ready/id/addr/data/isWr/mask   client N request channel
//   cN_resp_valid/ready/id/data      client N response channel
//   mem_req_valid/ready/id/addr/data/isWr/mask  downstream request channel
//   mem_resp_valid/ready/id/data     downstream response channel
//   busy                             requests outstanding or grant locked
//   err                              sticky unexpected-response flag
// -----------------------------------------------------------------------------
module dram_port_arbiter
    import dram_pkg::*;
#(
    parameter int CLIENT_ID_W     = 3,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 4
) (
    input  logic                   clock,
    input  logic                   reset,

    input  logic                   c0_req_valid,
    output logic                   c0_req_ready,
    input  logic [CLIENT_ID_W-1:0] c0_req_id,
    input  logic [DRAM_ADDR_W-1:0] c0_req_addr,
    input  logic [DRAM_DATA_W-1:0] c0_req_data,
    input  logic                   c0_req_isWr,
    input  logic [DRAM_MASK_W-1:0] c0_req_mask,
    output logic                   c0_resp_valid,
    input  logic                   c0_resp_ready,
    output logic [CLIENT_ID_W-1:0] c0_resp_id,
    output logic [DRAM_DATA_W-1:0] c0_resp_data,

    input  logic                   c1_req_valid,
    output logic                   c1_req_ready,
    input  logic [CLIENT_ID_W-1:0] c1_req_id,
    input  logic [DRAM_ADDR_W-1:0] c1_req_addr,
    input  logic [DRAM_DATA_W-1:0] c1_req_data,
    input  logic                   c1_req_isWr,
    input  logic [DRAM_MASK_W-1:0] c1_req_mask,
    output logic                   c1_resp_valid,
    input  logic                   c1_resp_ready,
    output logic [CLIENT_ID_W-1:0] c1_resp_id,
    output logic [DRAM_DATA_W-1:0] c1_resp_data,

    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [DRAM_ID_W-1:0]   mem_req_id,
    output logic [DRAM_ADDR_W-1:0] mem_req_addr,
    output logic [DRAM_DATA_W-1:0] mem_req_data,
    output logic                   mem_req_isWr,
    output logic [DRAM_MASK_W-1:0] mem_req_mask,

    input  logic                   mem_resp_valid,
    output logic                   mem_resp_ready,
    input  logic [DRAM_ID_W-1:0]   mem_resp_id,
    input  logic [DRAM_DATA_W-1:0] mem_resp_data,

    output logic                   busy,
    output logic                   err
);

    logic [1:0]       req_valid;
    logic [1:0]       req_elig;
    logic [1:0]       req_fire;
    logic [1:0]       resp_fire;
    logic             gnt_idx;
    logic             gnt_valid;
    logic             arb_locked;
    logic             resp_k;
    dram_req_t        req_sel;
    dram_resp_t       resp_in;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic             err_q;
    logic             err_d;

    // ---------------- request arbitration ----------------
    assign req_valid = {c1_req_valid, c0_req_valid};

    always_comb begin
        req_elig = '0;
        for (int n = 0; n < 2; n++) begin
            req_elig[n] = req_valid[n] && (cnt_q[n] < CNT_W'(MAX_OUTSTANDING));
        end
    end

    rr_arb2 u_arb (
        .clock       (clock),
        .reset       (reset),
        .req_valid_i (req_valid),
        .req_elig_i  (req_elig),
        .ready_i     (mem_req_ready),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid),
        .locked_o    (arb_locked)
    );

    // Zero-latency mux of the granted client onto the downstream port.
    always_comb begin
        if (gnt_idx) begin
            req_sel.id   = {1'b1, c1_req_id};
            req_sel.addr = c1_req_addr;
            req_sel.data = c1_req_data;
            req_sel.isWr = c1_req_isWr;
            req_sel.mask = c1_req_mask;
        end else begin
            req_sel.id   = {1'b0, c0_req_id};
            req_sel.addr = c0_req_addr;
            req_sel.data = c0_req_data;
            req_sel.isWr = c0_req_isWr;
            req_sel.mask = c0_req_mask;
        end
    end

    assign mem_req_valid = gnt_valid;
    assign mem_req_id    = req_sel.id;
    assign mem_req_addr  = req_sel.addr;
    assign mem_req_data  = req_sel.data;
    assign mem_req_isWr  = req_sel.isWr;
    assign mem_req_mask  = req_sel.mask;

    assign c0_req_ready = mem_req_ready && mem_req_valid && !gnt_idx;
    assign c1_req_ready = mem_req_ready && mem_req_valid &&  gnt_idx;
    assign req_fire     = {c1_req_ready, c0_req_ready};

    // ---------------- response routing ----------------
    assign resp_in.id   = mem_resp_id;
    assign resp_in.data = mem_resp_data;
    assign resp_k       = resp_in.id[DRAM_ID_W-1];

    assign c0_resp_valid  = mem_resp_valid && !resp_k && !reset;
    assign c1_resp_valid  = mem_resp_valid &&  resp_k && !reset;
    assign c0_resp_id     = resp_in.id[CLIENT_ID_W-1:0];
    assign c1_resp_id     = resp_in.id[CLIENT_ID_W-1:0];
    assign c0_resp_data   = resp_in.data;
    assign c1_resp_data   = resp_in.data;
    assign mem_resp_ready = !reset && (resp_k ? c1_resp_ready : c0_resp_ready);
    assign resp_fire      = {c1_resp_valid && c1_resp_ready,
                             c0_resp_valid && c0_resp_ready};

    // ---------------- outstanding tracking ----------------
    always_comb begin
        err_d = err_q;
        for (int n = 0; n < 2; n++) begin
            cnt_d[n] = cnt_q[n];
            // An unexpected response is flagged and must not underflow.
            if (resp_fire[n] && (cnt_q[n] == '0)) begin
                err_d = 1'b1;
            end
            case ({req_fire[n], resp_fire[n] && (cnt_q[n] != '0)})
                2'b10:   cnt_d[n] = cnt_q[n] + CNT_W'(1);
                2'b01:   cnt_d[n] = cnt_q[n] - CNT_W'(1);
                default: cnt_d[n] = cnt_q[n];
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int n = 0; n < 2; n++) begin
                cnt_q[n] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
            err_q <= err_d;
        end
    end

    assign busy = (cnt_q[0] != '0) || (cnt_q[1] != '0) || arb_locked;
    assign err  = err_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
module tb_dram_port_arbiter;

    logic         clock = 1'b0;
    logic         reset;
    logic         c0_req_valid, c0_req_ready, c0_req_isWr;
    logic [2:0]   c0_req_id;
    logic [31:0]  c0_req_addr;
    logic [127:0] c0_req_data;
    logic [15:0]  c0_req_mask;
    logic         c0_resp_valid, c0_resp_ready;
    logic [2:0]   c0_resp_id;
    logic [127:0] c0_resp_data;
    logic         c1_req_valid, c1_req_ready, c1_req_isWr;
    logic [2:0]   c1_req_id;
    logic [31:0]  c1_req_addr;
    logic [127:0] c1_req_data;
    logic [15:0]  c1_req_mask;
    logic         c1_resp_valid, c1_resp_ready;
    logic [2:0]   c1_resp_id;
    logic [127:0] c1_resp_data;
    logic         mem_req_valid, mem_req_ready, mem_req_isWr;
    logic [3:0]   mem_req_id;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic [15:0]  mem_req_mask;
    logic         mem_resp_valid, mem_resp_ready;
    logic [3:0]   mem_resp_id;
    logic [127:0] mem_resp_data;
    logic         busy, err;

    typedef struct {
        logic         cl;
        logic [2:0]   id;
        logic [127:0] data;
    } rsp_t;

    rsp_t rsp_q[$];
    int   gnt_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    dram_port_arbiter dut (
        .clock(clock), .reset(reset),
        .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready), .c0_req_id(c0_req_id),
        .c0_req_addr(c0_req_addr), .c0_req_data(c0_req_data), .c0_req_isWr(c0_req_isWr),
        .c0_req_mask(c0_req_mask), .c0_resp_valid(c0_resp_valid), .c0_resp_ready(c0_resp_ready),
        .c0_resp_id(c0_resp_id), .c0_resp_data(c0_resp_data),
        .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready), .c1_req_id(c1_req_id),
        .c1_req_addr(c1_req_addr), .c1_req_data(c1_req_data), .c1_req_isWr(c1_req_isWr),
        .c1_req_mask(c1_req_mask), .c1_resp_valid(c1_resp_valid), .c1_resp_ready(c1_resp_ready),
        .c1_resp_id(c1_resp_id), .c1_resp_data(c1_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_id(mem_req_id),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_isWr(mem_req_isWr),
        .mem_req_mask(mem_req_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
        .mem_resp_id(mem_resp_id), .mem_resp_data(mem_resp_data),
        .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [127:0] mk_data(input logic cl, input logic [2:0] id);
        return {28'hDA7A000, cl, id, 32'h1234_5678, 28'h0, ~cl, ~id, 32'hAAAA_AAAA};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        c0_req_valid = 0; c0_req_id = 0; c0_req_addr = 0; c0_req_data = 0;
        c0_req_isWr = 0; c0_req_mask = 0; c0_resp_ready = 0;
        c1_req_valid = 0; c1_req_id = 0; c1_req_addr = 0; c1_req_data = 0;
        c1_req_isWr = 0; c1_req_mask = 0; c1_resp_ready = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_id = 0; mem_resp_data = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
        rsp_q.delete();
    endtask

    // Acts as the DRAM model: returns every queued response in order and
    // checks that each one is routed to the right client unchanged.
    task automatic return_responses();
        rsp_t e;
        logic v, other;
        logic [2:0] id;
        logic [127:0] d;
        while (rsp_q.size() > 0) begin
            e = rsp_q.pop_front();
            mem_resp_valid = 1; mem_resp_id = {e.cl, e.id}; mem_resp_data = e.data;
            c0_resp_ready = 1; c1_resp_ready = 1;
            settle();
            v     = e.cl ? c1_resp_valid : c0_resp_valid;
            other = e.cl ? c0_resp_valid : c1_resp_valid;
            id    = e.cl ? c1_resp_id : c0_resp_id;
            d     = e.cl ? c1_resp_data : c0_resp_data;
            n_cmp++;
            if ({v, other, mem_resp_ready, id, d} !== {1'b1, 1'b0, 1'b1, e.id, e.data}) begin
                n_bad++;
                $display("FAIL resp_route cl=%0d: got v=%b other=%b rdy=%b id=%0d data=%h, want v=1 other=0 rdy=1 id=%0d data=%h",
                         e.cl, v, other, mem_resp_ready, id, d, e.id, e.data);
            end
            step();
        end
        mem_resp_valid = 0; c0_resp_ready = 0; c1_resp_ready = 0;
        settle();
        n_cmp++;
        if ({busy, err} !== 2'b00) begin
            n_bad++; $display("FAIL drained_idle: got busy=%b err=%b, want 0 0", busy, err);
        end
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        c0_req_valid = 1; c1_req_valid = 1; mem_req_ready = 1;
        mem_resp_valid = 1; mem_resp_id = 4'h9; c0_resp_ready = 1; c1_resp_ready = 1;
        step();
        step();
        n_cmp++;
        if ({mem_req_valid, c0_req_ready, c1_req_ready, c0_resp_valid, c1_resp_valid} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_valids: got %b, want 00000",
                     {mem_req_valid, c0_req_ready, c1_req_ready, c0_resp_valid, c1_resp_valid});
        end
        n_cmp++;
        if ({busy, err} !== 2'b00) begin
            n_bad++; $display("FAIL reset_state: got busy=%b err=%b, want 0 0", busy, err);
        end
        reset = 0;
        clear_inputs();
        step();
    endtask

    task automatic test_single_read();
        do_reset();
        c0_req_valid = 1; c0_req_id = 3'd5; c0_req_addr = 32'h100; c0_req_mask = 16'hFFFF;
        mem_req_ready = 1;
        settle();
        n_cmp++;
        if ({mem_req_valid, mem_req_id, mem_req_addr, c0_req_ready, c1_req_ready} !==
            {1'b1, 4'h5, 32'h100, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL single_req: got v=%b id=%h addr=%h r0=%b r1=%b, want 1 5 100 1 0",
                     mem_req_valid, mem_req_id, mem_req_addr, c0_req_ready, c1_req_ready);
        end
        step();
        c0_req_valid = 0; mem_req_ready = 0;
        settle();
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b, want 1", busy); end
        rsp_q.push_back('{cl: 1'b0, id: 3'd5, data: {16{8'hAA}}});
        return_responses();
    endtask

    task automatic test_contention();
        int exp;
        logic [3:0] exp_id;
        do_reset();
        for (int i = 0; i < 8; i++) gnt_q.push_back(i % 2);
        c0_req_valid = 1; c1_req_valid = 1; mem_req_ready = 1;
        for (int i = 0; i < 8; i++) begin
            c0_req_id = 3'(i); c1_req_id = 3'(7 - i);
            c0_req_addr = 32'h2000 + 32'(i * 16); c1_req_addr = 32'h8000 + 32'(i * 16);
            settle();
            exp = gnt_q.pop_front();
            exp_id = (exp == 1) ? {1'b1, c1_req_id} : {1'b0, c0_req_id};
            n_cmp++;
            if ({mem_req_valid, mem_req_id, c0_req_ready, c1_req_ready} !==
                {1'b1, exp_id, exp == 0, exp == 1}) begin
                n_bad++;
                $display("FAIL contention_grant[%0d]: got v=%b id=%h r0=%b r1=%b, want client %0d id=%h",
                         i, mem_req_valid, mem_req_id, c0_req_ready, c1_req_ready, exp, exp_id);
            end
            rsp_q.push_back('{cl: exp_id[3], id: exp_id[2:0], data: mk_data(exp_id[3], exp_id[2:0])});
            step();
        end
        c0_req_valid = 0; c1_req_valid = 0; mem_req_ready = 0;
        return_responses();
    endtask

    task automatic test_lock();
        do_reset();
        c1_req_valid = 1; c1_req_id = 3'd3; c1_req_addr = 32'h200; c1_req_isWr = 1;
        c1_req_mask = 16'h00F0; c1_req_data = mk_data(1'b1, 3'd3);
        settle();
        n_cmp++;
        if ({mem_req_valid, mem_req_id, mem_req_isWr, mem_req_mask, c1_req_ready} !==
            {1'b1, 4'hB, 1'b1, 16'h00F0, 1'b0}) begin
            n_bad++;
            $display("FAIL lock_first: got v=%b id=%h wr=%b mask=%h r1=%b, want 1 b 1 00f0 0",
                     mem_req_valid, mem_req_id, mem_req_isWr, mem_req_mask, c1_req_ready);
        end
        step();
        c0_req_valid = 1; c0_req_id = 3'd4; c0_req_addr = 32'h300;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_cmp++;
            if ({mem_req_id, mem_req_addr, c0_req_ready, c1_req_ready, busy} !==
                {4'hB, 32'h200, 1'b0, 1'b0, 1'b1}) begin
                n_bad++;
                $display("FAIL lock_hold[%0d]: got id=%h addr=%h r0=%b r1=%b busy=%b, want b 200 0 0 1",
                         i, mem_req_id, mem_req_addr, c0_req_ready, c1_req_ready, busy);
            end
            step();
        end
        mem_req_ready = 1;
        settle();
        n_cmp++;
        if ({mem_req_id, c0_req_ready, c1_req_ready} !== {4'hB, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL lock_fire: got id=%h r0=%b r1=%b, want b 0 1", mem_req_id, c0_req_ready, c1_req_ready);
        end
        rsp_q.push_back('{cl: 1'b1, id: 3'd3, data: mk_data(1'b1, 3'd3)});
        step();
        c1_req_valid = 0;
        settle();
        n_cmp++;
        if ({mem_req_id, mem_req_addr, c0_req_ready} !== {4'h4, 32'h300, 1'b1}) begin
            n_bad++;
            $display("FAIL lock_next: got id=%h addr=%h r0=%b, want 4 300 1", mem_req_id, mem_req_addr, c0_req_ready);
        end
        rsp_q.push_back('{cl: 1'b0, id: 3'd4, data: mk_data(1'b0, 3'd4)});
        step();
        c0_req_valid = 0; mem_req_ready = 0;
        return_responses();
    endtask

    task automatic test_cap();
        do_reset();
        mem_req_ready = 1; c0_req_valid = 1;
        for (int i = 0; i < 4; i++) begin
            c0_req_id = 3'(i); c0_req_addr = 32'h1000 + 32'(i * 16);
            settle();
            n_cmp++;
            if ({c0_req_ready, mem_req_id} !== {1'b1, 1'b0, 3'(i)}) begin
                n_bad++; $display("FAIL cap_fill[%0d]: got r0=%b id=%h, want 1 %0d", i, c0_req_ready, mem_req_id, i);
            end
            rsp_q.push_back('{cl: 1'b0, id: 3'(i), data: mk_data(1'b0, 3'(i))});
            step();
        end
        c0_req_id = 3'd4; c1_req_valid = 1; c1_req_id = 3'd1;
        settle();
        n_cmp++;
        if ({c0_req_ready, c1_req_ready, mem_req_id} !== {1'b0, 1'b1, 4'h9}) begin
            n_bad++;
            $display("FAIL cap_block: got r0=%b r1=%b id=%h, want 0 1 9", c0_req_ready, c1_req_ready, mem_req_id);
        end
        rsp_q.push_back('{cl: 1'b1, id: 3'd1, data: mk_data(1'b1, 3'd1)});
        step();
        c1_req_valid = 0;
        settle();
        n_cmp++;
        if ({mem_req_valid, c0_req_ready} !== 2'b00) begin
            n_bad++; $display("FAIL cap_stall: got v=%b r0=%b, want 0 0", mem_req_valid, c0_req_ready);
        end
        step();
        mem_resp_valid = 1; mem_resp_id = 4'h2; mem_resp_data = mk_data(1'b0, 3'd2); c0_resp_ready = 1;
        settle();
        n_cmp++;
        if ({c0_resp_valid, c0_resp_id, c0_req_ready} !== {1'b1, 3'd2, 1'b0}) begin
            n_bad++;
            $display("FAIL cap_resp: got v=%b id=%0d r0=%b, want 1 2 0", c0_resp_valid, c0_resp_id, c0_req_ready);
        end
        for (int j = 0; j < rsp_q.size(); j++) begin
            if (rsp_q[j].cl == 1'b0 && rsp_q[j].id == 3'd2) begin
                rsp_q.delete(j);
                break;
            end
        end
        step();
        mem_resp_valid = 0; c0_resp_ready = 0;
        settle();
        n_cmp++;
        if ({c0_req_ready, mem_req_id} !== {1'b1, 4'h4}) begin
            n_bad++; $display("FAIL cap_release: got r0=%b id=%h, want 1 4", c0_req_ready, mem_req_id);
        end
        rsp_q.push_back('{cl: 1'b0, id: 3'd4, data: mk_data(1'b0, 3'd4)});
        step();
        c0_req_valid = 0; mem_req_ready = 0;
        return_responses();
    endtask

    task automatic test_simultaneous();
        do_reset();
        mem_req_ready = 1; c0_req_valid = 1;
        for (int i = 0; i < 2; i++) begin
            c0_req_id = 3'(i);
            rsp_q.push_back('{cl: 1'b0, id: 3'(i), data: mk_data(1'b0, 3'(i))});
            step();
        end
        c0_req_id = 3'd2;
        mem_resp_valid = 1; mem_resp_id = 4'h0; mem_resp_data = mk_data(1'b0, 3'd0); c0_resp_ready = 1;
        settle();
        n_cmp++;
        if ({c0_req_ready, c0_resp_valid, c0_resp_id} !== {1'b1, 1'b1, 3'd0}) begin
            n_bad++;
            $display("FAIL simul_both: got r0=%b rv=%b rid=%0d, want 1 1 0", c0_req_ready, c0_resp_valid, c0_resp_id);
        end
        void'(rsp_q.pop_front());
        rsp_q.push_back('{cl: 1'b0, id: 3'd2, data: mk_data(1'b0, 3'd2)});
        step();
        mem_resp_valid = 0; c0_resp_ready = 0;
        // Outstanding is now 2: exactly two more may go before the cap.
        for (int i = 3; i < 5; i++) begin
            c0_req_id = 3'(i);
            settle();
            n_cmp++;
            if (c0_req_ready !== 1'b1) begin
                n_bad++; $display("FAIL simul_room[%0d]: got r0=%b, want 1", i, c0_req_ready);
            end
            rsp_q.push_back('{cl: 1'b0, id: 3'(i), data: mk_data(1'b0, 3'(i))});
            step();
        end
        c0_req_id = 3'd5;
        settle();
        n_cmp++;
        if ({c0_req_ready, mem_req_valid} !== 2'b00) begin
            n_bad++; $display("FAIL simul_cap: got r0=%b v=%b, want 0 0", c0_req_ready, mem_req_valid);
        end
        c0_req_valid = 0; mem_req_ready = 0;
        step();
        return_responses();
    endtask

    task automatic test_error_reset();
        do_reset();
        mem_resp_valid = 1; mem_resp_id = 4'h9; mem_resp_data = mk_data(1'b1, 3'd1); c1_resp_ready = 1;
        settle();
        n_cmp++;
        if ({c1_resp_valid, c0_resp_valid, c1_resp_id, mem_resp_ready, c1_resp_data, err} !==
            {1'b1, 1'b0, 3'd1, 1'b1, mk_data(1'b1, 3'd1), 1'b0}) begin
            n_bad++;
            $display("FAIL err_forward: got v1=%b v0=%b id=%0d rdy=%b err=%b, want 1 0 1 1 0",
                     c1_resp_valid, c0_resp_valid, c1_resp_id, mem_resp_ready, err);
        end
        step();
        mem_resp_valid = 0; c1_resp_ready = 0;
        settle();
        n_cmp++;
        if ({err, busy} !== 2'b10) begin
            n_bad++; $display("FAIL err_set: got err=%b busy=%b, want 1 0", err, busy);
        end
        step(); step();
        n_cmp++;
        if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b, want 1", err); end
        c1_req_valid = 1; c1_req_id = 3'd6; mem_req_ready = 1;
        settle();
        n_cmp++;
        if ({c1_req_ready, mem_req_id} !== {1'b1, 4'hE}) begin
            n_bad++; $display("FAIL err_no_underflow: got r1=%b id=%h, want 1 e", c1_req_ready, mem_req_id);
        end
        step();
        c1_req_valid = 0; mem_req_ready = 0;
        settle();
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL err_busy: got %b, want 1", busy); end
        // Reset while a c1 request is outstanding; its late response must flag err.
        reset = 1; c0_req_valid = 1; mem_req_ready = 1;
        mem_resp_valid = 1; mem_resp_id = 4'hE; c1_resp_ready = 1;
        settle();
        n_cmp++;
        if ({mem_req_valid, c0_req_ready, c1_req_ready, c0_resp_valid, c1_resp_valid} !== 5'b0) begin
            n_bad++;
            $display("FAIL midreset_valids: got %b, want 00000",
                     {mem_req_valid, c0_req_ready, c1_req_ready, c0_resp_valid, c1_resp_valid});
        end
        step();
        n_cmp++;
        if ({err, busy} !== 2'b00) begin
            n_bad++; $display("FAIL midreset_clear: got err=%b busy=%b, want 0 0", err, busy);
        end
        reset = 0; c0_req_valid = 0; mem_req_ready = 0;
        settle();
        n_cmp++;
        if ({c1_resp_valid, c1_resp_id} !== {1'b1, 3'd6}) begin
            n_bad++; $display("FAIL late_resp_fwd: got v=%b id=%0d, want 1 6", c1_resp_valid, c1_resp_id);
        end
        step();
        mem_resp_valid = 0; c1_resp_ready = 0;
        settle();
        n_cmp++;
        if (err !== 1'b1) begin n_bad++; $display("FAIL late_resp_err: got %b, want 1", err); end
        do_reset();
        settle();
        n_cmp++;
        if ({err, busy, mem_req_valid, c0_resp_valid, c1_resp_valid} !== 5'b0) begin
            n_bad++;
            $display("FAIL final_reset: got err=%b busy=%b v=%b rv0=%b rv1=%b, want all 0",
                     err, busy, mem_req_valid, c0_resp_valid, c1_resp_valid);
        end
        step();
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_lock();
        test_cap();
        test_simultaneous();
        test_error_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
